// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming encoder with a 2-entry output buffer and per-word bit-flip injection.
// Define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED codeword).
module hamming_stream_encoder #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W = (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6,
  localparam int unsigned HAM_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
  localparam int unsigned CW_W  = HAM_W + 1,
`else
  localparam int unsigned CW_W  = HAM_W,
`endif
  localparam int unsigned POS_W = $clog2(CW_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic [POS_W-1:0]  inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_code,
  output logic [CNT_W-1:0]  word_cnt
);

  // Hamming position (1-based) of data bit idx: the idx-th non-power-of-two position.
  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned n;
    int unsigned res;
    n   = 0;
    res = 0;
    for (int unsigned p = 3; p <= 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx && res == 0) res = p;
        n++;
      end
    end
    return res;
  endfunction

  // Data positions covered by parity bit p(2**k).
  function automatic logic [HAM_W-1:0] cover_mask(int unsigned k);
    logic [HAM_W-1:0] m;
    m = '0;
    for (int unsigned p = 1; p <= HAM_W; p++) begin
      if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0) m = m | (HAM_W'(1) << (p - 1));
    end
    return m;
  endfunction

  logic [HAM_W-1:0] data_placed;
  logic [PAR_W-1:0] par;
  logic [HAM_W-1:0] ham;
  logic [CW_W-1:0]  code_enc;
  logic [CW_W-1:0]  inj_mask;
  logic [CW_W-1:0]  code_inj;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    assign data_placed[data_pos(i) - 1] = in_data[i];
  end

  for (genvar k = 0; k < PAR_W; k++) begin : g_par
    localparam logic [HAM_W-1:0] Cover = cover_mask(k);
    assign data_placed[(1 << k) - 1] = 1'b0;
    assign par[k] = ^(data_placed & Cover);
  end

  for (genvar p = 1; p <= HAM_W; p++) begin : g_pos
    if ((p & (p - 1)) == 0) begin : g_is_par
      assign ham[p - 1] = par[$clog2(p)];
    end else begin : g_is_data
      assign ham[p - 1] = data_placed[p - 1];
    end
  end

`ifdef HAMMING_SECDED_EN
  assign code_enc = {^ham, ham};
`else
  assign code_enc = ham;
`endif

  localparam logic [POS_W-1:0] CwLim = POS_W'(CW_W);

  // Injection is applied last so it can also corrupt the overall parity bit.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos < CwLim)) inj_mask = {{(CW_W - 1){1'b0}}, 1'b1} << inj_pos;
  end

  assign code_inj = code_enc ^ inj_mask;

  logic [CW_W-1:0]  mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;
  logic             out_sel;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // When empty, the last popped entry sits behind the read pointer and is held on out_code.
  assign out_sel  = (count_q == 2'd0) ? ~rd_ptr_q : rd_ptr_q;
  assign out_code = mem_q[out_sel];
  assign word_cnt = cnt_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= code_inj;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Self-checking bench for hamming_stream_encoder: directed vectors plus randomized traffic
// checked against a syndrome-based reference model and a queue scoreboard.
module tb_hamming_stream_encoder;

  localparam int unsigned DATA_W = 4;

  function automatic int unsigned calc_par_w(int unsigned dw);
    int unsigned r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int unsigned PAR_W = calc_par_w(DATA_W);
  localparam int unsigned HAM_W = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
  localparam int unsigned CW_W  = HAM_W + 1;
`else
  localparam int unsigned CW_W  = HAM_W;
`endif
  localparam int unsigned POS_W = $clog2(CW_W + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              inj_en = 1'b0;
  logic [POS_W-1:0]  inj_pos = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [CW_W-1:0]   out_code;
  logic [15:0]       word_cnt;
  logic              s_in_ready;
  logic              s_out_valid;
  logic [CW_W-1:0]   s_out_code;
  logic [3:0]        s_word_cnt;

  always #5 clk = ~clk;

  hamming_stream_encoder #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .word_cnt(word_cnt)
  );

  hamming_stream_encoder #(.DATA_W(DATA_W), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_code(s_out_code), .word_cnt(s_word_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [CW_W-1:0] exp_q[$];
  logic [CW_W-1:0] last_code = '0;
  int cnt_model = 0;

  // Parity chosen so the XOR of the positions of all set bits is zero.
  function automatic logic [CW_W-1:0] ref_code(logic [DATA_W-1:0] d, logic ie,
                                               logic [POS_W-1:0] ip);
    logic [CW_W-1:0] c;
    int di;
    int syn;
    c = '0;
    di = 0;
    syn = 0;
    for (int p = 1; p <= HAM_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[di];
        if (d[di]) syn = syn ^ p;
        di++;
      end
    end
    for (int k = 0; k < PAR_W; k++) c[(1 << k) - 1] = syn[k];
`ifdef HAMMING_SECDED_EN
    c[CW_W-1] = ($countones(c) % 2) != 0;
`endif
    if (ie && int'(ip) < CW_W) c[ip] = ~c[ip];
    return c;
  endfunction

  // Advance one clock and update the scoreboard from the model's own occupancy.
  task automatic step();
    bit do_push;
    bit do_pop;
    do_pop  = out_ready && exp_q.size() > 0;
    do_push = in_valid && exp_q.size() < 2;
    @(posedge clk);
    if (do_pop) begin
      last_code = exp_q.pop_front();
      cnt_model++;
    end
    if (do_push) exp_q.push_back(ref_code(in_data, inj_en, inj_pos));
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inj_en    = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #3;
    exp_q.delete();
    last_code = '0;
    cnt_model = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_code !== '0 || word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_vals: out_code=%h word_cnt=%0d, expected 0 0", out_code, word_cnt);
    end
  endtask

  task automatic test_vectors();
    logic [DATA_W-1:0] dv [3];
    logic [CW_W-1:0]   ev [3];
    dv[0] = 4'b1011;
    dv[1] = 4'b0001;
    dv[2] = 4'b0000;
`ifdef HAMMING_SECDED_EN
    ev[0] = 8'h55;
    ev[1] = 8'h87;
    ev[2] = 8'h00;
`else
    ev[0] = 7'h55;
    ev[1] = 7'h07;
    ev[2] = 7'h00;
`endif
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = dv[i];
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_code !== ev[i]) begin
        errors++;
        $display("FAIL vector[%0d]: out_valid=%b out_code=%h, expected 1 %h",
                 i, out_valid, out_code, ev[i]);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_code !== ev[i]) begin
        errors++;
        $display("FAIL vector_hold[%0d]: out_valid=%b out_code=%h, expected 0 %h",
                 i, out_valid, out_code, ev[i]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_injection();
    logic [POS_W-1:0] pv [3];
    logic [CW_W-1:0]  ev [3];
    pv[0] = POS_W'(2);
    ev[0] = CW_W'(4);
    pv[1] = POS_W'(CW_W);
    ev[1] = '0;
    pv[2] = '1;
    ev[2] = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = '0;
      inj_en   = 1'b1;
      inj_pos  = pv[i];
      step();
      in_valid = 1'b0;
      inj_en   = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_code !== ev[i]) begin
        errors++;
        $display("FAIL inject[pos=%0d]: out_valid=%b out_code=%h, expected 1 %h",
                 pv[i], out_valid, out_code, ev[i]);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] w [3];
    int idx;
    int start_cnt;
    logic [CW_W-1:0] exp_c;
    for (int i = 0; i < 3; i++) w[i] = DATA_W'($urandom);
    start_cnt = cnt_model;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = w[idx];
      if (exp_q.size() < 2) idx++;
      step();
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: in_ready=%b, expected %b", c, in_ready, exp_q.size() < 2);
      end
    end
    checks++;
    if (in_ready !== 1'b0 || out_code !== ref_code(w[0], 1'b0, '0)) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b out_code=%h, expected 0 %h",
               in_ready, out_code, ref_code(w[0], 1'b0, '0));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && (idx < 3 || exp_q.size() > 0); c++) begin
      in_valid = idx < 3;
      in_data  = w[(idx < 3) ? idx : 2];
      if (idx < 3 && exp_q.size() < 2) idx++;
      step();
      exp_c = exp_q.size() > 0 ? exp_q[0] : last_code;
      checks++;
      if (out_valid !== (exp_q.size() > 0) || out_code !== exp_c) begin
        errors++;
        $display("FAIL bp_drain[%0d]: out_valid=%b out_code=%h, expected %b %h",
                 c, out_valid, out_code, exp_q.size() > 0, exp_c);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (last_code !== ref_code(w[2], 1'b0, '0) || int'(word_cnt) !== start_cnt + 3) begin
      errors++;
      $display("FAIL bp_order: last=%h word_cnt=%0d, expected %h %0d",
               last_code, word_cnt, ref_code(w[2], 1'b0, '0), start_cnt + 3);
    end
  endtask

  task automatic test_stream();
    logic [CW_W-1:0] exp_c;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      step();
      exp_c = exp_q[0];
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp_c || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: out_valid=%b in_ready=%b out_code=%h, expected 1 1 %h",
                 c, out_valid, in_ready, out_code, exp_c);
      end
      checks++;
      if (s_out_valid !== 1'b1 || s_out_code !== exp_c || s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_small[%0d]: out_valid=%b in_ready=%b out_code=%h, expected 1 1 %h",
                 c, s_out_valid, s_in_ready, s_out_code, exp_c);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (word_cnt !== 16'd100 || s_word_cnt !== 4'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_cnt: word_cnt=%0d small=%0d out_valid=%b, expected 100 4 0",
               word_cnt, s_word_cnt, out_valid);
    end
  endtask

  task automatic test_random();
    logic [CW_W-1:0] exp_c;
    for (int c = 0; c < 300; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_data   = DATA_W'($urandom);
      inj_en    = $urandom_range(0, 3) == 0;
      inj_pos   = POS_W'($urandom_range(0, (1 << POS_W) - 1));
      step();
      exp_c = exp_q.size() > 0 ? exp_q[0] : last_code;
      checks++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) ||
          out_code !== exp_c || int'(word_cnt) !== (cnt_model % 65536)) begin
        errors++;
        $display("FAIL random[%0d]: v=%b r=%b code=%h cnt=%0d, expected %b %b %h %0d", c,
                 out_valid, in_ready, out_code, word_cnt, exp_q.size() > 0,
                 exp_q.size() < 2, exp_c, cnt_model);
      end
    end
    in_valid = 1'b0;
    inj_en   = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || word_cnt === 16'd0) begin
      errors++;
      $display("FAIL areset_pre: out_valid=%b in_ready=%b word_cnt=%0d, expected 1 0 nonzero",
               out_valid, in_ready, word_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 16'd0 || out_code !== '0) begin
      errors++;
      $display("FAIL areset: out_valid=%b in_ready=%b word_cnt=%0d code=%h, expected 0 1 0 0",
               out_valid, in_ready, word_cnt, out_code);
    end
    exp_q.delete();
    last_code = '0;
    cnt_model = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 17; c++) begin
      in_data = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (s_word_cnt !== 4'd1 || word_cnt !== 16'd17) begin
      errors++;
      $display("FAIL cnt_wrap: small=%0d big=%0d, expected 1 17", s_word_cnt, word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_injection();
    test_backpressure();
    test_stream();
    test_random();
    test_async_reset();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
